timer_bank: RTL and testbench



---
 rtl/timer_bank.sv | 142 ++++++++++++++
 tb/tb_timer_bank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable down-counter peripheral on the 8-bit
// CPU bus. Each channel has a reload register, one-shot/periodic mode, an
// optional prescaler and a sticky expiry flag; flags gated by IE form irq.
//
// Bus protocol: an access is qualified by cs for exactly the cycle it is
// presented. cs & we writes dbw into the addressed register at that edge;
// cs & !we loads dbr at that edge, so read data is valid the following cycle
// and dbr holds until the next read. There is no wait state or back-pressure.
module timer_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [4:0] addr,
  input  logic       cs,
  input  logic       we,
  output logic       irq
);

  localparam int BYTES = WIDTH / 8;

  logic [WIDTH-1:0]    counter  [CHANNELS];
  logic [WIDTH-1:0]    reload   [CHANNELS];
  logic [WIDTH-1:0]    snapshot [CHANNELS];
  logic [7:0]          pdiv     [CHANNELS];
  logic [7:0]          pcount   [CHANNELS];
  logic [CHANNELS-1:0] en, per, ie, pse, flag;

  logic [CHANNELS-1:0] wr, rd, load, tick, expire;
  logic [2:0]          reg_sel;
  logic [7:0]          rd_data;
  logic                unused_bits;

  assign reg_sel     = addr[2:0];
  assign unused_bits = &{1'b0, dbw[6:5]};

  // Per-channel decode, tick generation and expiry detection.
  // LOAD suppresses the expiry of the same cycle, so LOAD wins over a tick.
  always_comb begin
    wr     = '0;
    rd     = '0;
    load   = '0;
    tick   = '0;
    expire = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr[c]     = cs & we & (addr[4:3] == 2'(c));
      rd[c]     = cs & ~we & (addr[4:3] == 2'(c));
      load[c]   = wr[c] & (reg_sel == 3'd4) & dbw[4];
      tick[c]   = en[c] & (~pse[c] | (pcount[c] == pdiv[c]));
      expire[c] = tick[c] & (counter[c] == '0) & ~load[c];
    end
  end

  // Read data mux; count byte 0 is live, higher bytes come from the snapshot.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd[c]) begin
        for (int b = 0; b < BYTES; b++) begin
          if (reg_sel == 3'(b)) begin
            if (b == 0) rd_data = counter[c][7:0];
            else        rd_data = snapshot[c][8*b +: 8];
          end
        end
        case (reg_sel)
          3'd4:    rd_data = {4'b0000, pse[c], ie[c], per[c], en[c]};
          3'd5:    rd_data = {flag[c], 7'b0000000};
          3'd6:    rd_data = pdiv[c];
          default: ;
        endcase
      end
    end
  end

  // Channel state: registers, counting, prescaler and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        counter[c]  <= '0;
        reload[c]   <= '0;
        snapshot[c] <= '0;
        pdiv[c]     <= '0;
        pcount[c]   <= '0;
      end
      en   <= '0;
      per  <= '0;
      ie   <= '0;
      pse  <= '0;
      flag <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wr[c] && reg_sel == 3'(b)) reload[c][8*b +: 8] <= dbw;
        end

        // A control write overrides the hardware EN clear of a one-shot.
        if (wr[c] && reg_sel == 3'd4) begin
          en[c]  <= dbw[0];
          per[c] <= dbw[1];
          ie[c]  <= dbw[2];
          pse[c] <= dbw[3];
        end else if (expire[c] && !per[c]) begin
          en[c] <= 1'b0;
        end

        if (wr[c] && reg_sel == 3'd6) pdiv[c] <= dbw;

        if (rd[c] && reg_sel == 3'd0) snapshot[c] <= counter[c];

        if (load[c]) begin
          counter[c] <= reload[c];
        end else if (tick[c]) begin
          if (counter[c] != '0) counter[c] <= counter[c] - WIDTH'(1);
          else if (per[c])      counter[c] <= reload[c];
        end

        if (en[c] && pse[c]) pcount[c] <= (pcount[c] == pdiv[c]) ? 8'd0 : pcount[c] + 8'd1;
        else                 pcount[c] <= 8'd0;

        // Hardware set has priority over the write-one-to-clear.
        if (expire[c])                                flag[c] <= 1'b1;
        else if (wr[c] && reg_sel == 3'd5 && dbw[7]) flag[c] <= 1'b0;
      end
    end
  end

  // Registered bus read data; holds when no read is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dbr <= 8'h00;
    else if (cs & ~we) dbr <= rd_data;
  end

  // Registered level interrupt from enabled flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(flag & ie);
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random bus
// traffic, compared against a behavioural model of the timer rules.
module tb_timer_bank;

  localparam int WIDTH = 16;
  localparam int CH    = 2;
  localparam int BYTES = WIDTH / 8;
  localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;

  logic       clk;
  logic       rst;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [4:0] addr;
  logic       cs;
  logic       we;
  logic       irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] irq_q[$];
  logic       rd_seen;

  // Behavioural model state.
  longint unsigned m_cnt[4], m_rel[4], m_snap[4];
  int              m_p[4], m_pc[4];
  bit              m_en[4], m_per[4], m_ie[4], m_pse[4], m_flag[4];
  bit              m_irq;

  timer_bank #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk  (clk),
    .rst  (rst),
    .dbr  (dbr),
    .dbw  (dbw),
    .addr (addr),
    .cs   (cs),
    .we   (we),
    .irq  (irq)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Marks cycles where dbr carries read data.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= cs & ~we;
  end

  // Monitor: compare irq every driven cycle and dbr after every read.
  always @(negedge clk) begin
    if (irq_q.size() > 0) check("irq", {7'b0, irq}, irq_q.pop_front());
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dbr_unexpected: got %h expected no read", dbr);
      end else begin
        check("dbr", dbr, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_snap[c] = 0;
      m_p[c] = 0; m_pc[c] = 0;
      m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pse[c] = 0; m_flag[c] = 0;
    end
    m_irq = 0;
  endtask

  // One clock edge of the timer rules applied to the bus access presented.
  task automatic model_step(input bit c_s, input bit w_e, input logic [4:0] a,
                            input logic [7:0] d, output bit is_rd, output logic [7:0] rv);
    int  ch;
    int  rg;
    bit  acc_w;
    bit  new_irq;
    bit  tk, ld, ex, old_per;
    ch    = int'(a[4:3]);
    rg    = int'(a[2:0]);
    rv    = 8'h00;
    is_rd = c_s && !w_e;
    acc_w = c_s && w_e && ch < CH;

    if (is_rd && ch < CH) begin
      if (rg <= 3) begin
        if (rg < BYTES) begin
          if (rg == 0) rv = 8'(m_cnt[ch] & 255);
          else         rv = 8'((m_snap[ch] >> (8 * rg)) & 255);
        end
        if (rg == 0) m_snap[ch] = m_cnt[ch];
      end else if (rg == 4) begin
        rv = {4'b0, m_pse[ch], m_ie[ch], m_per[ch], m_en[ch]};
      end else if (rg == 5) begin
        rv = {m_flag[ch], 7'b0};
      end else if (rg == 6) begin
        rv = 8'(m_p[ch]);
      end
    end

    new_irq = 0;
    for (int c = 0; c < CH; c++) new_irq |= m_flag[c] & m_ie[c];

    for (int c = 0; c < CH; c++) begin
      bit mine;
      mine    = acc_w && ch == c;
      old_per = m_per[c];
      tk      = m_en[c] && (!m_pse[c] || m_pc[c] == m_p[c]);
      ld      = mine && rg == 4 && d[4];
      ex      = tk && m_cnt[c] == 0 && !ld;

      m_pc[c] = (m_en[c] && m_pse[c]) ? ((m_pc[c] == m_p[c]) ? 0 : m_pc[c] + 1) : 0;

      if (ld)           m_cnt[c] = m_rel[c];
      else if (tk)      m_cnt[c] = (m_cnt[c] != 0) ? m_cnt[c] - 1 : (old_per ? m_rel[c] : 0);

      if (mine && rg < BYTES)
        m_rel[c] = ((m_rel[c] & ~(longint'(255) << (8 * rg))) | (longint'(d) << (8 * rg))) & MASK;

      if (mine && rg == 4) begin
        m_en[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2]; m_pse[c] = d[3];
      end else if (ex && !old_per) begin
        m_en[c] = 0;
      end

      if (mine && rg == 6) m_p[c] = int'(d);

      if (ex)                          m_flag[c] = 1;
      else if (mine && rg == 5 && d[7]) m_flag[c] = 0;
    end
    m_irq = new_irq;
  endtask

  // Driver: present one bus cycle and queue the model's expectations.
  task automatic cycle(input bit r, input bit c_s, input bit w_e,
                       input logic [4:0] a, input logic [7:0] d);
    bit         is_rd;
    logic [7:0] rv;
    @(negedge clk);
    #1;
    rst = r; cs = c_s; we = w_e; addr = a; dbw = d;
    if (r) begin
      model_reset();
      irq_q.push_back(8'h00);
    end else begin
      model_step(c_s, w_e, a, d, is_rd, rv);
      if (is_rd) exp_q.push_back(rv);
      irq_q.push_back({7'b0, m_irq});
    end
  endtask

  function automatic logic [4:0] ra(input int ch, input int rg);
    return {2'(ch), 3'(rg)};
  endfunction

  task automatic bus_wr(input int ch, input int rg, input logic [7:0] d);
    cycle(0, 1, 1, ra(ch, rg), d);
  endtask

  task automatic bus_rd(input int ch, input int rg);
    cycle(0, 1, 0, ra(ch, rg), 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'd0, 8'h00);
  endtask

  // Stimulus sequence and final report.
  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; dbw = '0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 5'd0, 8'h00);

    // Reset mid-count then read back every register of both channels.
    bus_wr(0, 0, 8'h20);
    bus_wr(0, 6, 8'h03);
    bus_wr(0, 4, 8'h17);
    bus_wr(1, 0, 8'h05);
    bus_wr(1, 4, 8'h13);
    idle(5);
    cycle(1, 0, 0, 5'd0, 8'h00);
    cycle(1, 0, 0, 5'd0, 8'h00);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++) bus_rd(c, r);

    // Periodic, no prescaler, with interrupt and W1C.
    bus_wr(0, 0, 8'h03);
    bus_wr(0, 1, 8'h00);
    bus_wr(0, 4, 8'h17);
    idle(10);
    bus_rd(0, 5);
    bus_wr(0, 5, 8'h80);
    idle(6);
    bus_wr(0, 4, 8'h04);
    bus_wr(0, 5, 8'h80);
    idle(2);

    // One-shot with prescaler, IE clear.
    bus_wr(1, 0, 8'h02);
    bus_wr(1, 6, 8'h04);
    bus_wr(1, 4, 8'h19);
    idle(13);
    bus_rd(1, 5);
    idle(5);
    bus_rd(1, 4);
    bus_rd(1, 0);
    bus_rd(1, 5);
    bus_wr(1, 5, 8'h80);

    // Coherent multi-byte read.
    bus_wr(0, 0, 8'h00);
    bus_wr(0, 1, 8'h01);
    bus_wr(0, 4, 8'h13);
    bus_rd(0, 0);
    idle(4);
    bus_rd(0, 1);
    bus_rd(0, 0);
    bus_wr(0, 4, 8'h00);
    bus_wr(0, 5, 8'h80);

    // LOAD on the expiry cycle, then W1C on the expiry cycle.
    bus_wr(0, 0, 8'h03);
    bus_wr(0, 1, 8'h00);
    bus_wr(0, 4, 8'h13);
    idle(3);
    bus_wr(0, 4, 8'h13);
    bus_rd(0, 5);
    idle(2);
    bus_wr(0, 5, 8'h80);
    bus_rd(0, 5);
    bus_wr(0, 4, 8'h00);
    bus_wr(0, 5, 8'h80);
    bus_rd(0, 5);

    // Out-of-range channel and byte index.
    bus_wr(3, 0, 8'h55);
    bus_wr(3, 4, 8'h17);
    bus_wr(3, 6, 8'h09);
    bus_wr(0, 2, 8'hAA);
    bus_wr(0, 7, 8'hFF);
    bus_rd(3, 0);
    bus_rd(3, 4);
    bus_rd(3, 6);
    bus_rd(0, 2);
    bus_rd(0, 7);
    bus_rd(2, 5);
    bus_rd(0, 0);

    // Random bus traffic.
    for (int i = 0; i < 500; i++) begin
      bit         c_s, w_e;
      logic [4:0] a;
      logic [7:0] d;
      c_s = ($urandom_range(0, 3) == 0);
      w_e = $urandom_range(0, 1);
      a   = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      d   = 8'($urandom_range(0, 255));
      if (a[2:0] == 3'd6) d = 8'($urandom_range(0, 3));
      if (a[2:0] == 3'd1) d = 8'($urandom_range(0, 1));
      cycle(0, c_s, w_e, a, d);
    end
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 7; r++) bus_rd(c, r);

    idle(3);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || irq_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d reads and %0d irq entries left expected 0", exp_q.size(), irq_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
